// File: rtl/dff_share_pkg.sv
// -----------------------------------------------------------------------------
// dff_share_pkg
//   Shared definitions for the shared D-register arbiter:
//     - state_t   : arbiter FSM state encoding (ST_IDLE, ST_WRITE, ST_HOLD)
//     - clog2_min1: ceil(log2(value)), never less than 1, used to size the
//                   owner/pointer and hold counter fields
// -----------------------------------------------------------------------------
package dff_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // A zero-width field is not legal, so small values still get one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// -----------------------------------------------------------------------------
// dff_reg
//   WIDTH-bit D-register with write enable and true/complement outputs.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-high reset, clears the register to 0
//     en_i  in   write enable; d_i is captured on the rising edge when high
//     d_i   in   WIDTH-bit data
//     q_o   out  register contents
//     qb_o  out  bitwise complement of q_o (all ones while in reset)
// -----------------------------------------------------------------------------
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  // qb is derived from the single stored copy so it can never disagree with q.
  assign q_o  = data_q;
  assign qb_o = ~data_q;

endmodule

// File: rtl/dff_share_arbiter.sv
// -----------------------------------------------------------------------------
// dff_share_arbiter
//   Shares one WIDTH-bit register between N_REQ requesters. A round-robin
//   arbiter grants one requester, performs a single write of its data, holds
//   the grant for HOLD_CYC cycles, then returns to IDLE for at least a cycle.
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     req       in   per-requester level request
//     wr_data   in   requester i data at [i*WIDTH +: WIDTH]
//     gnt       out  registered one-hot grant (or zero)
//     busy      out  high whenever the FSM is not in IDLE
//     owner     out  index of the current or most recent grantee
//     q / qb    out  shared register contents and its complement
//     wr_count  out  number of completed writes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WIDTH    = 8,
  parameter  int HOLD_CYC = 2,
  localparam int OW       = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [OW-1:0]          owner,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qb,
  output logic [7:0]             wr_count
);

  localparam int CW = clog2_min1(HOLD_CYC + 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [OW-1:0]    sel;
  logic             sel_valid;
  logic [OW-1:0]    scan_idx;
  logic             wr_en;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [WIDTH-1:0] wr_sel_data;

  // Unpack the flat data bus so the write mux is a simple array index.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = wr_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign wr_sel_data = data_arr[owner_q];

  // Round-robin pick: scan from ptr+1 upward with wrap, first set request wins.
  // Starting just past the last grantee makes it the lowest priority.
  always_comb begin
    sel       = ptr_q;
    sel_valid = 1'b0;
    scan_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = OW'((int'(ptr_q) + i) % N_REQ);
      if (!sel_valid && req[scan_idx]) begin
        sel       = scan_idx;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        hold_d = '0;
        if (sel_valid) begin
          state_d = ST_WRITE;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          owner_d = sel;
          ptr_d   = sel;
        end
      end

      ST_WRITE: begin
        if (req[owner_q]) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (HOLD_CYC == 0) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end else begin
            state_d = ST_HOLD;
            hold_d  = CW'(1);
          end
        end else begin
          // Owner withdrew before the write: abandon it, pointer already moved.
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if ((hold_q >= CW'(HOLD_CYC)) || !req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N_REQ - 1);
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  dff_reg #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (wr_en),
    .d_i  (wr_sel_data),
    .q_o  (q),
    .qb_o (qb)
  );

  assign gnt      = gnt_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  q, qb, wr_count;

  // Second build with HOLD_CYC=0
  logic [3:0]  req0;
  logic [31:0] wr_data0;
  logic [3:0]  gnt0;
  logic        busy0;
  logic [1:0]  owner0;
  logic [7:0]  q0, qb0, wr_count0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         o;
    logic [7:0] d;
    logic [7:0] c;
  } wr_t;

  int  gq[$];
  wr_t wq[$];
  logic [7:0] exp_cnt = 8'd0;

  dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data),
    .gnt(gnt), .busy(busy), .owner(owner), .q(q), .qb(qb), .wr_count(wr_count)
  );

  dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr_data(wr_data0),
    .gnt(gnt0), .busy(busy0), .owner(owner0), .q(q0), .qb(qb0), .wr_count(wr_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s act=event exp=none", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int o);
    gq.push_back(o);
  endtask

  task automatic push_wr(input int o, input logic [7:0] d);
    wr_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.o = o; e.d = d; e.c = exp_cnt;
    wq.push_back(e);
  endtask

  // Run until the grant drops, then withdraw all requests. hi = cycles gnt seen high.
  task automatic serve(output int hi);
    hi = 0;
    do begin
      step(1);
      if (gnt != 4'b0) hi++;
    end while (gnt != 4'b0 && hi < 40);
    if (hi >= 40) fail_now("serve_timeout");
    req = 4'b0;
  endtask

  // Scoreboard monitor: pops an expected grant on each grant rise and an
  // expected write on each wr_count change.
  logic [7:0] prev_cnt = 8'd0;
  logic [3:0] prev_gnt = 4'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = 8'd0;
      prev_gnt = 4'b0;
    end else begin
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (gq.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          int eo;
          logic [3:0] oh;
          eo = gq.pop_front();
          oh = 4'b0001 << eo;
          chk("mon_gnt", {28'b0, gnt}, {28'b0, oh});
          chk("mon_owner", {30'b0, owner}, eo);
        end
      end
      if (wr_count != prev_cnt) begin
        if (wq.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("mon_q", {24'b0, q}, {24'b0, e.d});
          chk("mon_qb", {24'b0, qb}, {24'b0, ~e.d});
          chk("mon_cnt", {24'b0, wr_count}, {24'b0, e.c});
          chk("mon_wr_owner", {30'b0, owner}, e.o);
        end
      end
      prev_cnt = wr_count;
      prev_gnt = gnt;
    end
  end

  initial begin
    int hi;
    int n;
    rst = 1'b1; req = 4'b0; wr_data = 32'h0; req0 = 4'b0; wr_data0 = 32'h0;
    step(2);
    chk("rst_gnt", {28'b0, gnt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_q", {24'b0, q}, 32'h00);
    chk("rst_qb", {24'b0, qb}, 32'hFF);
    chk("rst_cnt", {24'b0, wr_count}, 0);
    chk("rst_owner", {30'b0, owner}, 0);
    rst = 1'b0;
    step(1);

    // Single request from requester 2
    wr_data[23:16] = 8'hA5;
    push_grant(2); push_wr(2, 8'hA5);
    req = 4'b0100;
    step(1);
    chk("t2_gnt", {28'b0, gnt}, 32'h4);
    chk("t2_busy", {31'b0, busy}, 1);
    step(1);
    chk("t2_q", {24'b0, q}, 32'hA5);
    chk("t2_qb", {24'b0, qb}, 32'h5A);
    serve(hi);
    chk("t2_gnt_len", 2 + hi, 3);
    step(1);

    // Reset asserted mid-HOLD takes effect without a clock edge
    wr_data[15:8] = 8'hC3;
    push_grant(1); push_wr(1, 8'hC3);
    req = 4'b0010;
    step(2);
    chk("t1_in_hold", {31'b0, busy}, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t1_gnt", {28'b0, gnt}, 0);
    chk("t1_busy", {31'b0, busy}, 0);
    chk("t1_q", {24'b0, q}, 32'h00);
    chk("t1_qb", {24'b0, qb}, 32'hFF);
    chk("t1_cnt", {24'b0, wr_count}, 0);
    req = 4'b0;
    exp_cnt = 8'd0;
    step(2);
    rst = 1'b0;
    step(1);

    // Round-robin with all four requesting: 0,1,2,3,0
    wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push_grant(0); push_wr(0, 8'h11);
    push_grant(1); push_wr(1, 8'h22);
    push_grant(2); push_wr(2, 8'h33);
    push_grant(3); push_wr(3, 8'h44);
    push_grant(0); push_wr(0, 8'h11);
    req = 4'b1111;
    n = 0;
    while (wr_count != 8'd5 && n < 40) begin
      step(1);
      n++;
    end
    chk("t3_cycles_to_5", n, 18);
    serve(hi);
    chk("t3_cnt", {24'b0, wr_count}, 5);
    step(1);

    // Early release in first HOLD cycle (ptr=0 -> requester 3 next)
    wr_data[31:24] = 8'h5E;
    push_grant(3); push_wr(3, 8'h5E);
    req = 4'b1000;
    step(2);
    req = 4'b0;
    step(1);
    chk("t4_gnt", {28'b0, gnt}, 0);
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_q", {24'b0, q}, 32'h5E);
    step(1);

    // Aborted write: requester 0 drops during WRITE
    wr_data[7:0] = 8'h77;
    push_grant(0);
    req = 4'b0001;
    step(1);
    chk("t5_gnt", {28'b0, gnt}, 32'h1);
    req = 4'b0;
    step(1);
    chk("t5_gnt_off", {28'b0, gnt}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_q", {24'b0, q}, 32'h5E);
    chk("t5_cnt", {24'b0, wr_count}, 6);
    // ptr advanced to 0, so requester 1 beats requester 0
    wr_data[15:8] = 8'h99;
    push_grant(1); push_wr(1, 8'h99);
    req = 4'b0011;
    serve(hi);
    chk("t5_cnt_after", {24'b0, wr_count}, 7);
    step(1);

    // wr_count wrap: 256 writes from reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_cnt = 8'd0;
    step(1);
    wr_data[23:16] = 8'hE1;
    for (int k = 0; k < 256; k++) begin
      push_grant(2);
      push_wr(2, 8'hE1);
    end
    req = 4'b0100;
    n = 0;
    while ((wq.size() != 0 || gq.size() != 0) && n < 1100) begin
      step(1);
      n++;
    end
    req = 4'b0;
    chk("t6_queue_drained", n < 1100, 1);
    step(3);
    chk("t6_cnt_wrap", {24'b0, wr_count}, 0);
    chk("t6_q", {24'b0, q}, 32'hE1);
    chk("t6_gnt", {28'b0, gnt}, 0);

    // HOLD_CYC=0 build: grant lasts exactly one cycle
    wr_data0[15:8] = 8'h6B;
    req0 = 4'b0010;
    step(1);
    chk("h0_gnt", {28'b0, gnt0}, 32'h2);
    chk("h0_busy", {31'b0, busy0}, 1);
    step(1);
    req0 = 4'b0;
    chk("h0_gnt_off", {28'b0, gnt0}, 0);
    chk("h0_busy_off", {31'b0, busy0}, 0);
    chk("h0_q", {24'b0, q0}, 32'h6B);
    chk("h0_qb", {24'b0, qb0}, 32'h94);
    chk("h0_cnt", {24'b0, wr_count0}, 1);
    step(2);
    chk("h0_stay_idle", {28'b0, gnt0}, 0);

    if (gq.size() != 0 || wq.size() != 0) fail_now("leftover_expectations");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
